// File: rtl/tinyalu_arbiter_if.sv
// tinyalu_arbiter_if: requester command/response and TinyALU pins of the arbiter
interface tinyalu_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_A;
    logic [8*NUM_REQ-1:0] req_B;
    logic [3*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [15:0]          rsp_result;
    logic                 rsp_error;
    logic                 alu_start;
    logic [2:0]           alu_op;
    logic [7:0]           alu_A;
    logic [7:0]           alu_B;
    logic                 alu_done;
    logic [15:0]          alu_result;
    modport slave (
        input  req_valid, req_A, req_B, req_op, alu_done, alu_result,
        output req_ready, rsp_valid, rsp_result, rsp_error, alu_start, alu_op, alu_A, alu_B
    );
    modport master (
        output req_valid, req_A, req_B, req_op, alu_done, alu_result,
        input  req_ready, rsp_valid, rsp_result, rsp_error, alu_start, alu_op, alu_A, alu_B
    );
endinterface

// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin sharing of one TinyALU between NUM_REQ requesters
module tinyalu_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ALU_TIMEOUT = 15
) (
    input logic              clk,
    input logic              reset_n,
    tinyalu_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ALU_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t          state, state_n;
    logic [IW-1:0]   ptr, idx, gidx, gnext;
    logic [NUM_REQ-1:0] grant;
    logic            found, take, legal, tmo;
    logic [2:0]      g_op, op_q;
    logic [7:0]      a_q, b_q;
    logic [CW-1:0]   cnt;
    logic [15:0]     result_q;
    logic            error_q;
    // first valid requester at or after ptr, wrapping around
    always_comb begin
        int j;
        j = 0;
        grant = '0;
        gidx = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            if (!found && bus.req_valid[j]) begin
                found = 1'b1;
                gidx = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end
    assign gnext = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    assign g_op  = bus.req_op[3*int'(gidx) +: 3];
    assign legal = (g_op != 3'd0) && (g_op <= 3'd4);
    assign take  = (state == IDLE) && found;
    assign tmo   = (cnt == CW'(ALU_TIMEOUT - 1));
    assign bus.req_ready  = (state == IDLE && reset_n) ? grant : '0;
    assign bus.rsp_result = result_q;
    assign bus.rsp_error  = error_q;
    // next state and ALU/response strobes; ALU pins stay zero outside ISSUE
    always_comb begin
        state_n = state;
        bus.alu_start = 1'b0;
        bus.alu_op = '0;
        bus.alu_A = '0;
        bus.alu_B = '0;
        bus.rsp_valid = '0;
        case (state)
            IDLE: state_n = found ? (legal ? ISSUE : RESP) : IDLE;
            ISSUE: begin
                bus.alu_start = 1'b1;
                bus.alu_op = op_q;
                bus.alu_A = a_q;
                bus.alu_B = b_q;
                state_n = (bus.alu_done || tmo) ? RESP : ISSUE;
            end
            RESP: begin
                bus.rsp_valid[idx] = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // command latch, timeout counter and held response; done beats timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (take) begin
                ptr  <= gnext;
                idx  <= gidx;
                a_q  <= bus.req_A[8*int'(gidx) +: 8];
                b_q  <= bus.req_B[8*int'(gidx) +: 8];
                op_q <= g_op;
                cnt  <= '0;
                if (!legal) begin
                    result_q <= '0;
                    error_q  <= 1'b1;
                end
            end
            if (state == ISSUE) begin
                cnt <= cnt + 1'b1;
                if (bus.alu_done) begin
                    result_q <= bus.alu_result;
                    error_q  <= 1'b0;
                end else if (tmo) begin
                    result_q <= '0;
                    error_q  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: directed and random checks of the arbiter against a transaction model
module tb_tinyalu_arbiter;
    localparam int N  = 4;
    localparam int TO = 15;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    tinyalu_arbiter_if #(.NUM_REQ(N)) bus ();
    tinyalu_arbiter #(.NUM_REQ(N), .ALU_TIMEOUT(TO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    // requester agents: a pending command is offered until granted or dropped
    logic       pend_v [N];
    logic [7:0] pend_a [N];
    logic [7:0] pend_b [N];
    logic [2:0] pend_op [N];
    // ALU model: mode 0 random latency mix, 1 never done, 2 fixed latency alu_fix
    int alu_mode = 2;
    int alu_fix = 2;
    int alu_cnt = 0;
    int alu_lat = 0;
    // transaction model: phase 0 free, 1 operation at the ALU, 2 answering
    int m_phase = 0;
    int m_ptr = 0;
    int m_owner = 0;
    int m_cyc = 0;
    logic [7:0]  m_a = 0, m_b = 0;
    logic [2:0]  m_op = 0;
    logic [15:0] m_res = 0;
    logic        m_err = 0;
    // observations of the DUT
    int gq[$];
    logic [N-1:0] rq[$];
    logic got_rsp = 0;
    logic [N-1:0] last_vec = 0;
    logic [15:0] last_res = 0;
    logic last_err = 0;
    int run = 0, last_run = 0, bursts = 0;

    function automatic logic [15:0] calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1: return 16'(a) + 16'(b);
            3'd2: return {8'h00, a & b};
            3'd3: return {8'h00, a ^ b};
            3'd4: return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] op);
        return op >= 3'd1 && op <= 3'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr = 0;
        m_res = 0;
        m_err = 0;
        alu_cnt = 0;
    endtask

    task automatic step();
        logic [N-1:0] v, exp_ready;
        logic [8*N-1:0] av, bv;
        logic [3*N-1:0] ov;
        int pick;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            v[i] = pend_v[i];
            av[8*i +: 8] = pend_a[i];
            bv[8*i +: 8] = pend_b[i];
            ov[3*i +: 3] = pend_op[i];
        end
        bus.req_valid = v;
        bus.req_A = av;
        bus.req_B = bv;
        bus.req_op = ov;
        if (reset_n && bus.alu_start) begin
            alu_cnt++;
            if (alu_cnt == 1) begin
                if (alu_mode == 1) alu_lat = 0;
                else if (alu_mode == 2) alu_lat = alu_fix;
                else begin
                    int r;
                    r = $urandom_range(0, 9);
                    alu_lat = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 5);
                end
            end
            bus.alu_done = (alu_lat != 0) && (alu_cnt == alu_lat);
            bus.alu_result = bus.alu_done ? calc(bus.alu_op, bus.alu_A, bus.alu_B) : 16'($urandom);
        end else begin
            alu_cnt = 0;
            bus.alu_done = 1'b0;
            bus.alu_result = 16'($urandom);
        end
        #1;
        pick = -1;
        exp_ready = '0;
        if (reset_n && m_phase == 0)
            for (int k = 0; k < N; k++)
                if (pick < 0 && pend_v[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        if (pick >= 0) exp_ready[pick] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        chk("alu_start", 32'(bus.alu_start), 32'(m_phase == 1));
        chk("alu_op", 32'(bus.alu_op), (m_phase == 1) ? 32'(m_op) : 32'd0);
        chk("alu_A", 32'(bus.alu_A), (m_phase == 1) ? 32'(m_a) : 32'd0);
        chk("alu_B", 32'(bus.alu_B), (m_phase == 1) ? 32'(m_b) : 32'd0);
        chk("rsp_valid", 32'(bus.rsp_valid), (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
        chk("rsp_result", 32'(bus.rsp_result), 32'(m_res));
        chk("rsp_error", 32'(bus.rsp_error), 32'(m_err));
        if (bus.alu_start) begin
            if (run == 0) bursts++;
            run++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) gq.push_back(i);
        if (bus.rsp_valid != '0) begin
            rq.push_back(bus.rsp_valid);
            got_rsp = 1'b1;
            last_vec = bus.rsp_valid;
            last_res = bus.rsp_result;
            last_err = bus.rsp_error;
        end
        if (!reset_n) model_reset();
        else if (m_phase == 2) m_phase = 0;
        else if (m_phase == 1) begin
            m_cyc++;
            if (bus.alu_done) begin
                m_phase = 2;
                m_res = calc(m_op, m_a, m_b);
                m_err = 1'b0;
            end else if (m_cyc == TO) begin
                m_phase = 2;
                m_res = 16'h0000;
                m_err = 1'b1;
            end
        end else if (pick >= 0) begin
            m_owner = pick;
            m_ptr = (pick + 1) % N;
            m_a = pend_a[pick];
            m_b = pend_b[pick];
            m_op = pend_op[pick];
            pend_v[pick] = 1'b0;
            m_cyc = 0;
            if (is_legal(m_op)) m_phase = 1;
            else begin
                m_phase = 2;
                m_res = 16'h0000;
                m_err = 1'b1;
            end
        end
    endtask

    task automatic wait_rsp(input int max);
        int n;
        n = 0;
        got_rsp = 1'b0;
        while (!got_rsp && n < max) begin
            step();
            n++;
        end
        chk("rsp_within_bound", 32'(got_rsp), 32'd1);
    endtask

    task automatic offer(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        pend_v[i] = 1'b1;
        pend_a[i] = a;
        pend_b[i] = b;
        pend_op[i] = op;
    endtask

    initial begin
        int b0, n;
        for (int i = 0; i < N; i++) offer(i, 8'h00, 8'h00, 3'd0);
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        bus.req_valid = '0;
        bus.req_A = '0;
        bus.req_B = '0;
        bus.req_op = '0;
        bus.alu_done = 1'b0;
        bus.alu_result = '0;
        repeat (3) step();
        chk("reset_rsp_result", 32'(bus.rsp_result), 32'h0);
        chk("reset_alu_start", 32'(bus.alu_start), 32'h0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        reset_n = 1'b1;
        step();
        // all four requesting xor: round-robin 0,1,2,3,0
        alu_mode = 2;
        alu_fix = 2;
        gq.delete();
        rq.delete();
        n = 0;
        while (rq.size() < 5 && n < 100) begin
            for (int i = 0; i < N; i++)
                if (!pend_v[i]) offer(i, 8'($urandom), 8'($urandom), 3'd3);
            step();
            n++;
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        chk("rr_rsp_count", 32'(rq.size() >= 5), 32'd1);
        chk("rr_grant_count", 32'(gq.size() >= 5), 32'd1);
        if (gq.size() >= 5 && rq.size() >= 5) begin
            chk("rr_grant0", 32'(gq[0]), 32'd0);
            chk("rr_grant1", 32'(gq[1]), 32'd1);
            chk("rr_grant2", 32'(gq[2]), 32'd2);
            chk("rr_grant3", 32'(gq[3]), 32'd3);
            chk("rr_grant4", 32'(gq[4]), 32'd0);
            chk("rr_rsp0", 32'(rq[0]), 32'h1);
            chk("rr_rsp1", 32'(rq[1]), 32'h2);
            chk("rr_rsp2", 32'(rq[2]), 32'h4);
            chk("rr_rsp3", 32'(rq[3]), 32'h8);
            chk("rr_rsp4", 32'(rq[4]), 32'h1);
        end
        repeat (4) step();
        // add from requester 0
        b0 = bursts;
        offer(0, 8'h12, 8'h34, 3'd1);
        wait_rsp(30);
        chk("add_vec", 32'(last_vec), 32'h1);
        chk("add_result", 32'(last_res), 32'h0046);
        chk("add_error", 32'(last_err), 32'h0);
        chk("add_bursts", 32'(bursts - b0), 32'd1);
        // mul from requester 2, ALU takes 4 cycles
        alu_fix = 4;
        offer(2, 8'hFF, 8'hFF, 3'd4);
        wait_rsp(30);
        chk("mul_vec", 32'(last_vec), 32'h4);
        chk("mul_result", 32'(last_res), 32'hFE01);
        chk("mul_start_len", 32'(last_run), 32'd4);
        step();
        // illegal opcode from requester 1
        b0 = bursts;
        offer(1, 8'h55, 8'h66, 3'd7);
        wait_rsp(10);
        chk("ill_vec", 32'(last_vec), 32'h2);
        chk("ill_result", 32'(last_res), 32'h0);
        chk("ill_error", 32'(last_err), 32'h1);
        chk("ill_bursts", 32'(bursts - b0), 32'd0);
        // hung ALU, then normal service resumes
        alu_mode = 1;
        offer(3, 8'h01, 8'h02, 3'd1);
        wait_rsp(40);
        chk("hang_vec", 32'(last_vec), 32'h8);
        chk("hang_start_len", 32'(last_run), 32'd15);
        chk("hang_result", 32'(last_res), 32'h0);
        chk("hang_error", 32'(last_err), 32'h1);
        alu_mode = 2;
        alu_fix = 1;
        offer(0, 8'h05, 8'h05, 3'd1);
        wait_rsp(20);
        chk("after_hang_result", 32'(last_res), 32'h000A);
        chk("after_hang_error", 32'(last_err), 32'h0);
        // reset during an ALU operation
        alu_mode = 1;
        offer(1, 8'h21, 8'h43, 3'd2);
        n = 0;
        while (!bus.alu_start && n < 10) begin
            step();
            n++;
        end
        chk("issue_seen", 32'(bus.alu_start), 32'd1);
        repeat (3) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_alu_start", 32'(bus.alu_start), 32'h0);
        chk("rst_alu_pins", {bus.alu_op, bus.alu_A, bus.alu_B}, 32'h0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_error, bus.rsp_result}, 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        repeat (2) step();
        reset_n = 1'b1;
        alu_mode = 2;
        alu_fix = 2;
        gq.delete();
        offer(3, 8'h0F, 8'hF0, 3'd3);
        offer(0, 8'h03, 8'h04, 3'd4);
        step();
        chk("post_rst_first_grant", (gq.size() > 0) ? 32'(gq[0]) : 32'hFFFF, 32'd0);
        wait_rsp(20);
        chk("post_rst_vec0", 32'(last_vec), 32'h1);
        chk("post_rst_res0", 32'(last_res), 32'h000C);
        wait_rsp(20);
        chk("post_rst_vec3", 32'(last_vec), 32'h8);
        chk("post_rst_res3", 32'(last_res), 32'h00FF);
        // random traffic against the model
        alu_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) == 0)
                    offer(i, 8'($urandom), 8'($urandom),
                          ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 4)) : 3'($urandom_range(0, 7)));
                else if (pend_v[i] && $urandom_range(0, 19) == 0)
                    pend_v[i] = 1'b0;
            end
            step();
        end
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
        alu_mode = 2;
        alu_fix = 1;
        repeat (40) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
